// File: rtl/preg_free_list_if.sv
// preg_free_list_if: rename/retire side handshake bundle for the physical-register free list
interface preg_free_list_if #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32
);
  localparam int TAG_W = $clog2(NUM_PREGS);
  localparam int DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic             alloc_req;
  logic             alloc_valid;
  logic [TAG_W-1:0] alloc_tag;
  logic             free_en;
  logic [TAG_W-1:0] free_tag;
  logic             commit_en;
  logic             flush;
  logic [CNT_W-1:0] free_count;
  logic             empty;
  logic             full;
  logic             error;
  modport master (
    output alloc_req, free_en, free_tag, commit_en, flush,
    input  alloc_valid, alloc_tag, free_count, empty, full, error
  );
  modport slave (
    input  alloc_req, free_en, free_tag, commit_en, flush,
    output alloc_valid, alloc_tag, free_count, empty, full, error
  );
endinterface

// File: rtl/preg_free_list.sv
// preg_free_list: circular free list of physical tags with speculative/committed heads for one-cycle flush recovery
module preg_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32
) (
  input logic              clk,
  input logic              reset,
  preg_free_list_if.slave  bus
);
  localparam int TAG_W = $clog2(NUM_PREGS);
  localparam int DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  // pointers are {phase, index}; phase toggles each time the index wraps
  logic [TAG_W-1:0] r_entry [DEPTH];
  logic [IDX_W:0]   r_spec, r_commit, r_tail;
  logic             r_error;
  logic [IDX_W:0]   w_spec_nxt, w_commit_nxt, w_tail_nxt;
  logic [CNT_W-1:0] w_count;
  logic             w_alloc, w_free_ok, w_commit_ok, w_free_err, w_commit_err;
  function automatic logic [IDX_W:0] inc(input logic [IDX_W:0] p);
    return (p[IDX_W-1:0] == IDX_W'(DEPTH - 1)) ? {~p[IDX_W], IDX_W'(0)} : p + (IDX_W + 1)'(1);
  endfunction
  always_comb begin
    w_count = (r_tail[IDX_W] == r_spec[IDX_W])
            ? CNT_W'(r_tail[IDX_W-1:0]) - CNT_W'(r_spec[IDX_W-1:0])
            : CNT_W'(DEPTH) + CNT_W'(r_tail[IDX_W-1:0]) - CNT_W'(r_spec[IDX_W-1:0]);
    w_alloc      = bus.alloc_req && bus.alloc_valid;
    w_free_err   = bus.free_en && (w_count == CNT_W'(DEPTH)) && !w_alloc;
    w_free_ok    = bus.free_en && !w_free_err;
    w_commit_err = bus.commit_en && (r_commit == r_spec);
    w_commit_ok  = bus.commit_en && !w_commit_err;
    w_commit_nxt = w_commit_ok ? inc(r_commit) : r_commit;
    w_spec_nxt   = bus.flush ? w_commit_nxt : (w_alloc ? inc(r_spec) : r_spec);
    w_tail_nxt   = w_free_ok ? inc(r_tail) : r_tail;
  end
  assign bus.alloc_valid = !bus.flush && (w_count != '0);
  assign bus.alloc_tag   = r_entry[r_spec[IDX_W-1:0]];
  assign bus.free_count  = w_count;
  assign bus.empty       = (w_count == '0);
  assign bus.full        = (w_count == CNT_W'(DEPTH));
  assign bus.error       = r_error;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= TAG_W'(NUM_AREGS + i);
      r_spec   <= '0;
      r_commit <= '0;
      r_tail   <= {1'b1, IDX_W'(0)};
      r_error  <= 1'b0;
    end else begin
      if (w_free_ok) r_entry[r_tail[IDX_W-1:0]] <= bus.free_tag;
      r_spec   <= w_spec_nxt;
      r_commit <= w_commit_nxt;
      r_tail   <= w_tail_nxt;
      r_error  <= r_error || w_free_err || w_commit_err;
    end
  end
endmodule

// File: tb/tb_preg_free_list.sv
// tb_preg_free_list: directed self-checking bench for the physical-register free list
module tb_preg_free_list;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  preg_free_list_if #(.NUM_PREGS(64), .NUM_AREGS(32)) bus ();
  preg_free_list #(.NUM_PREGS(64), .NUM_AREGS(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    tick;
    reset = 1'b0;
  endtask
  task automatic idle;
    bus.alloc_req = 0;
    bus.free_en   = 0;
    bus.free_tag  = '0;
    bus.commit_en = 0;
    bus.flush     = 0;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask
  initial begin
    idle;
    tick;
    do_reset;
    #1;
    chk("rst_valid", 32'(bus.alloc_valid), 1);
    chk("rst_tag",   32'(bus.alloc_tag), 32);
    chk("rst_count", 32'(bus.free_count), 32);
    chk("rst_full",  32'(bus.full), 1);
    chk("rst_empty", 32'(bus.empty), 0);
    chk("rst_error", 32'(bus.error), 0);
    for (int i = 0; i < 32; i++) begin
      bus.alloc_req = 1;
      #1;
      chk("drain_valid", 32'(bus.alloc_valid), 1);
      chk("drain_tag",   32'(bus.alloc_tag), 32'(32 + i));
      tick;
    end
    bus.alloc_req = 0;
    #1;
    chk("empty_valid", 32'(bus.alloc_valid), 0);
    chk("empty_flag",  32'(bus.empty), 1);
    chk("empty_count", 32'(bus.free_count), 0);
    bus.alloc_req = 1;
    tick;
    bus.alloc_req = 0;
    #1;
    chk("extra_count", 32'(bus.free_count), 0);
    chk("extra_error", 32'(bus.error), 0);
    do_reset;
    for (int i = 0; i < 5; i++) begin
      bus.alloc_req = 1;
      #1;
      chk("pre_flush_tag", 32'(bus.alloc_tag), 32'(32 + i));
      tick;
    end
    bus.alloc_req = 0;
    bus.commit_en = 1;
    tick;
    tick;
    bus.commit_en = 0;
    bus.flush = 1;
    bus.alloc_req = 1;
    #1;
    chk("flush_valid", 32'(bus.alloc_valid), 0);
    tick;
    idle;
    #1;
    chk("flush_tag",   32'(bus.alloc_tag), 34);
    chk("flush_count", 32'(bus.free_count), 30);
    chk("flush_error", 32'(bus.error), 0);
    for (int i = 0; i < 30; i++) begin
      bus.alloc_req = 1;
      #1;
      chk("redrain_tag", 32'(bus.alloc_tag), 32'(34 + i));
      tick;
    end
    bus.alloc_req = 0;
    #1;
    chk("redrain_empty", 32'(bus.empty), 1);
    bus.free_en = 1;
    bus.free_tag = 7;
    bus.alloc_req = 1;
    #1;
    chk("nobypass_valid", 32'(bus.alloc_valid), 0);
    tick;
    idle;
    #1;
    chk("freed_valid", 32'(bus.alloc_valid), 1);
    chk("freed_tag",   32'(bus.alloc_tag), 7);
    chk("freed_count", 32'(bus.free_count), 1);
    do_reset;
    bus.free_en = 1;
    bus.free_tag = 5;
    tick;
    idle;
    #1;
    chk("ovf_error", 32'(bus.error), 1);
    chk("ovf_count", 32'(bus.free_count), 32);
    chk("ovf_tag",   32'(bus.alloc_tag), 32);
    tick;
    tick;
    chk("ovf_sticky", 32'(bus.error), 1);
    do_reset;
    #1;
    chk("ovf_cleared", 32'(bus.error), 0);
    bus.alloc_req = 1;
    bus.free_en = 1;
    bus.free_tag = 5;
    tick;
    idle;
    #1;
    chk("fullswap_error", 32'(bus.error), 0);
    chk("fullswap_count", 32'(bus.free_count), 32);
    chk("fullswap_tag",   32'(bus.alloc_tag), 33);
    do_reset;
    bus.commit_en = 1;
    tick;
    idle;
    #1;
    chk("badcommit_error", 32'(bus.error), 1);
    do_reset;
    for (int i = 0; i < 100; i++) begin
      bus.alloc_req = 1;
      bus.free_en = 1;
      bus.free_tag = 6'(32 + (i % 32));
      #1;
      chk("wrap_tag",   32'(bus.alloc_tag), 32'(32 + (i % 32)));
      chk("wrap_count", 32'(bus.free_count), 32);
      chk("wrap_full",  32'(bus.full), 1);
      chk("wrap_empty", 32'(bus.empty), 0);
      tick;
    end
    idle;
    #1;
    chk("wrap_error",    32'(bus.error), 0);
    chk("wrap_end_tag",  32'(bus.alloc_tag), 36);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
